// File: rtl/rv32i_pkg.sv
// Shared RV32I encoder types: format codes, NOP constant, request and
// output-word payload structs.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction format selector; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Encode request payload as presented on the input side.
    typedef struct packed {
        logic [2:0]      fmt;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
    } enc_req_t;

    // Encoded word plus its error flag, as stored in the output FIFO.
    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] instr;
    } enc_word_t;

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO for encoded words.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears contents)
//   i_push      write i_wdata (ignored when full)
//   i_wdata     word to store
//   i_pop       drop head entry (ignored when empty)
//   o_rdata     head entry, zero while empty
//   o_full      both slots occupied
//   o_empty     no slot occupied
module enc_fifo2
    import rv32i_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  enc_word_t i_wdata,
    input  logic      i_pop,
    output enc_word_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned CNT_BITS = 2;

    enc_word_t           r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_BITS'(2));
    assign o_empty = (r_count == CNT_BITS'(0));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is forced to zero when empty so no stale word is shown.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word per
// format, flags malformed requests, and buffers results in a 2-entry FIFO.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake
//   req_fmt .. req_imm     request fields
//   out_valid/out_ready    output handshake
//   out_instr, out_err     head word and its error flag
//   instr_count            completed output handshakes (wraps)
module instr_encoder
    import rv32i_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fmt,
    input  logic [6:0]       req_opcode,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [2:0]       req_func3,
    input  logic [6:0]       req_func7,
    input  logic [31:0]      req_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] instr_count
);

    enc_req_t         w_req;
    enc_word_t        w_word;
    enc_word_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_pop;
    logic             r_started;
    logic [CNT_W-1:0] r_instr_count;

    assign w_req = '{
        fmt:    req_fmt,
        opcode: req_opcode,
        rd:     req_rd,
        rs1:    req_rs1,
        rs2:    req_rs2,
        func3:  req_func3,
        func7:  req_func7,
        imm:    req_imm
    };

    // Holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    assign req_ready = r_started && !w_full;
    assign w_accept  = req_valid && req_ready;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    // Field packing per format; unused immediate bits are simply not selected.
    always_comb begin
        w_word       = '0;
        w_word.err   = 1'b0;
        w_word.instr = NOP_INSTR;
        case (w_req.fmt)
            FMT_R: w_word.instr = {w_req.func7, w_req.rs2, w_req.rs1,
                                   w_req.func3, w_req.rd, w_req.opcode};
            FMT_I: w_word.instr = {w_req.imm[11:0], w_req.rs1, w_req.func3,
                                   w_req.rd, w_req.opcode};
            FMT_S: w_word.instr = {w_req.imm[11:5], w_req.rs2, w_req.rs1,
                                   w_req.func3, w_req.imm[4:0], w_req.opcode};
            FMT_B: w_word.instr = {w_req.imm[12], w_req.imm[10:5], w_req.rs2,
                                   w_req.rs1, w_req.func3, w_req.imm[4:1],
                                   w_req.imm[11], w_req.opcode};
            FMT_U: w_word.instr = {w_req.imm[31:12], w_req.rd, w_req.opcode};
            FMT_J: w_word.instr = {w_req.imm[20], w_req.imm[10:1],
                                   w_req.imm[11], w_req.imm[19:12],
                                   w_req.rd, w_req.opcode};
            default: begin
                w_word.instr = NOP_INSTR;
                w_word.err   = 1'b1;
            end
        endcase
        // Non-32-bit opcode space, or misaligned branch/jump target.
        if (w_req.opcode[1:0] != 2'b11) begin
            w_word.err = 1'b1;
        end
        if ((w_req.fmt == FMT_B || w_req.fmt == FMT_J) && w_req.imm[0]) begin
            w_word.err = 1'b1;
        end
    end

    enc_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_instr = w_head.instr;
    assign out_err   = w_head.err;

    // Output handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_pop) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, backpressure,
// randomized traffic against a queue-based reference model, and reset.
module tb_instr_encoder;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_fmt = '0;
    logic [6:0]       req_opcode = '0;
    logic [4:0]       req_rd = '0;
    logic [4:0]       req_rs1 = '0;
    logic [4:0]       req_rs2 = '0;
    logic [2:0]       req_func3 = '0;
    logic [6:0]       req_func7 = '0;
    logic [31:0]      req_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fmt     (req_fmt),
        .req_opcode  (req_opcode),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_func3   (req_func3),
        .req_func7   (req_func7),
        .req_imm     (req_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_err     (out_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    // Reference encoding from bit-position arithmetic; returns {err, instr}.
    function automatic logic [32:0] model_encode(
        input int unsigned fmt, input int unsigned op, input int unsigned rd,
        input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
        input int unsigned f7, input int unsigned imm);
        int unsigned w;
        bit          e;
        e = 1'b0;
        case (fmt)
            0: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
            1: w = ((imm % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
            2: w = (((imm / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                   + ((imm % 32) << 7) + op;
            3: w = (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20)
                   + (rs1 << 15) + (f3 << 12) + (((imm / 2) % 16) << 8)
                   + (((imm / 2048) % 2) << 7) + op;
            4: w = (imm / 4096) * 4096 + (rd << 7) + op;
            5: w = (((imm / 1048576) % 2) << 31) + (((imm / 2) % 1024) << 21)
                   + (((imm / 2048) % 2) << 20) + (((imm / 4096) % 256) << 12)
                   + (rd << 7) + op;
            default: begin
                w = 32'h13;
                e = 1'b1;
            end
        endcase
        if (op % 4 != 3) e = 1'b1;
        if ((fmt == 3 || fmt == 5) && (imm % 2 == 1)) e = 1'b1;
        return {e, w};
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid  = 1'b1;
        req_fmt    = v.fmt;
        req_opcode = v.op;
        req_rd     = v.rd;
        req_rs1    = v.rs1;
        req_rs2    = v.rs2;
        req_func3  = v.f3;
        req_func7  = v.f7;
        req_imm    = v.imm;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #20;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 ||
            instr_count !== '0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b instr=%h err=%b cnt=%0d rdy=%b, want 0/0/0/0/0",
                     out_valid, out_instr, out_err, instr_count, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", req_ready);
        end
        exp_count = 0;
    endtask

    task automatic test_backpressure();
        vec_t a, b, c;
        a = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0};
        b = '{3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0};
        c = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(a);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b1 || out_instr !== a.exp_instr) begin
            errors++;
            $display("FAIL bp_first: rdy=%b valid=%b instr=%h want 1/1/%h",
                     req_ready, out_valid, out_instr, a.exp_instr);
        end
        drive_req(b);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b want 0", req_ready);
        end
        drive_req(c);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || out_instr !== a.exp_instr) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b instr=%h want 0/%h", req_ready, out_instr, a.exp_instr);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_instr !== b.exp_instr || instr_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL bp_second: rdy=%b instr=%h cnt=%0d want 1/%h/1",
                     req_ready, out_instr, instr_count, b.exp_instr);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL bp_drain: valid=%b cnt=%0d want 0/2", out_valid, instr_count);
        end
        exp_count = 2;
    endtask

    task automatic test_directed();
        vec_t v [8];
        v[0] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0};
        v[1] = '{3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0};
        v[2] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0};
        v[3] = '{3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1};
        v[4] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1};
        v[5] = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678, 32'h123450B7, 1'b0};
        v[6] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0};
        v[7] = '{3'd1, 7'h10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000010, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            drive_req(v[i]);
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== v[i].exp_instr || out_err !== v[i].exp_err) begin
                errors++;
                $display("FAIL directed[%0d]: valid=%b instr=%h err=%b want 1/%h/%b",
                         i, out_valid, out_instr, out_err, v[i].exp_instr, v[i].exp_err);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            exp_count++;
            checks++;
            if (out_valid !== 1'b0 || instr_count !== CNT_W'(exp_count)) begin
                errors++;
                $display("FAIL directed_pop[%0d]: valid=%b cnt=%0d want 0/%0d",
                         i, out_valid, instr_count, exp_count);
            end
        end
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        logic [32:0] e;
        vec_t        v;
        bit          model_rdy;
        bit          bad;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Compare DUT against model state reached after the previous edge.
            checks++;
            bad = (out_valid !== (q.size() > 0)) || (req_ready !== (q.size() < 2)) ||
                  (instr_count !== CNT_W'(exp_count));
            if (q.size() > 0 && {out_err, out_instr} !== q[0]) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b rdy=%b err=%b instr=%h cnt=%0d want occ=%0d head=%h cnt=%0d",
                         cyc, out_valid, req_ready, out_err, out_instr, instr_count,
                         q.size(), (q.size() > 0) ? q[0] : 33'h0, exp_count);
            end
            v.fmt = 3'($urandom_range(0, 7));
            v.op  = 7'($urandom);
            if ($urandom_range(0, 3) != 0) v.op[1:0] = 2'b11;
            v.rd  = 5'($urandom);
            v.rs1 = 5'($urandom);
            v.rs2 = 5'($urandom);
            v.f3  = 3'($urandom);
            v.f7  = 7'($urandom);
            v.imm = 32'($urandom);
            drive_req(v);
            req_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            model_rdy = (q.size() < 2);
            if (out_ready && q.size() > 0) begin
                void'(q.pop_front());
                exp_count++;
            end
            if (req_valid && model_rdy) begin
                e = model_encode(v.fmt, v.op, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.imm);
                q.push_back(e);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0) begin
            void'(q.pop_front());
            exp_count++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL random_drain: valid=%b cnt=%0d want 0/%0d", out_valid, instr_count, exp_count);
        end
    endtask

    task automatic test_reset_midop();
        vec_t a;
        a = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(a);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_fill: rdy=%b valid=%b want 0/1", req_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== '0 || out_instr !== 32'h0 ||
            out_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: valid=%b cnt=%0d instr=%h err=%b rdy=%b want 0/0/0/0/0",
                     out_valid, instr_count, out_instr, out_err, req_ready);
        end
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_recover: rdy=%b valid=%b want 1/0", req_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_directed();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the emitted-instruction counter.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  encode request present.
- req_ready  out  1  block accepts the request this cycle.
- req_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- req_opcode  in  7  opcode field.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_func3  in  3, req_func7  in  7  function fields.
- req_imm  in  32  sign-extended immediate.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word.
- out_instr  out  32  encoded RV32I word.
- out_err  out  1  error flag travelling with out_instr.
- instr_count  out  CNT_W  output handshakes completed.
REQ-003 Reset is asynchronous and active-low on rst_n; the block uses the single clock clk.

Function
REQ-004 A request SHALL be accepted on a rising clk edge with req_valid=1 and req_ready=1.
REQ-005 Encoding SHALL be registered: a word accepted at edge t SHALL be visible at out_instr/out_valid after edge t, with no combinational input-to-output path.
REQ-006 Encoded words SHALL be held in a 2-entry FIFO; req_ready=1 iff FIFO not full.
REQ-007 Output order SHALL equal acceptance order.
REQ-008 out_valid=1 iff FIFO not empty; out_instr and out_err SHALL show the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-009 Simultaneous push and pop with 1 entry SHALL keep occupancy at 1.
REQ-010 Pop from a full FIFO SHALL free a slot; req_ready rises in the following cycle.
REQ-011 R format = {func7, rs2, rs1, func3, rd, opcode}.
REQ-012 I format = {imm[11:0], rs1, func3, rd, opcode}.
REQ-013 S format = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-014 B format = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
REQ-015 U format = {imm[31:12], rd, opcode}.
REQ-016 J format = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-017 Illegal format SHALL emit 32'h00000013 (NOP) with out_err=1.
REQ-018 out_err=1 SHALL also be set when req_opcode[1:0] != 2'b11.
REQ-019 out_err=1 SHALL also be set for B or J with imm[0]=1; the word is still encoded, with bit 0 dropped.
REQ-020 Immediate bits outside the format's range SHALL be ignored without error.
REQ-021 instr_count SHALL increment by 1 per output handshake (out_valid=1 and out_ready=1) and wrap modulo 2^CNT_W.

Reset
REQ-022 While rst_n=0: FIFO empty, out_valid=0, out_instr=0, out_err=0, instr_count=0.
REQ-023 While rst_n=0, req_ready=0; it SHALL be 1 from the first clk edge after deassertion.
REQ-024 Reset mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.

Structure
REQ-025 Format encodings (R..J), the NOP constant and a request struct type SHALL live in a shared package, rv32i_pkg.
REQ-026 The 2-entry FIFO SHALL be a sub-module named enc_fifo2; field packing stays in instr_encoder.

Verification
REQ-027 R, opcode 0110011, rd=3, rs1=1, rs2=2, func3=0, func7=0 -> out_instr 0x002081B3, out_err 0, one cycle after accept.
REQ-028 I, opcode 0010011, rd=5, rs1=0, imm=0xFFFFFFFF -> 0xFFF00293.
REQ-029 S, opcode 0100011, func3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423.
REQ-030 out_ready=0, three back-to-back requests -> first two accepted, req_ready=0 on the third; on out_ready=1 both words emerge in order and instr_count=2.
REQ-031 fmt=7 -> 0x00000013, out_err=1; B with imm=3 -> out_err=1.
REQ-032 rst_n pulsed low with 2 entries buffered -> out_valid=0 and instr_count=0 immediately.
